// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with stall hold and redirect flush
// Holds {instruction, PC+4} pairs; head is zeroed (a NOP) whenever the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instrf,
    input  logic [31:0]   pcplus4f,
    input  logic          validf,
    output logic          readyf,
    output logic [31:0]   instrd,
    output logic [31:0]   pcplus4d,
    output logic          validd,
    input  logic          stalld,
    input  logic          flushd,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push, pop;

    assign readyf   = (count_q != FULL);
    assign validd   = (count_q != '0);
    assign count    = count_q;
    assign instrd   = validd ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pcplus4d = validd ? pc_mem_q[rd_ptr_q]    : 32'h0;

    assign push = validf & readyf;
    assign pop  = validd & ~stalld & ~flushd;

    // Reset and flush share one squash path; a same-cycle push is dropped.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (reset || flushd) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && !flushd && push) begin
            instr_mem_q[wr_ptr_q] <= instrf;
            pc_mem_q[wr_ptr_q]    <= pcplus4f;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instrf = '0, pcplus4f = '0;
    logic          validf = 1'b0, stalld = 1'b0, flushd = 1'b0;
    logic          readyf, validd;
    logic [31:0]   instrd, pcplus4d;
    logic [AW:0]   count;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .instrf(instrf), .pcplus4f(pcplus4f),
        .validf(validf), .readyf(readyf), .instrd(instrd), .pcplus4d(pcplus4d),
        .validd(validd), .stalld(stalld), .flushd(flushd), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        int          exp_count;
        logic        exp_validd;
        logic        exp_readyf;
    } vec_t;

    entry_t sb[$];
    bit     model_known = 0;
    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare of the current head, then one clock with the given inputs.
    task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic stall, input logic flush);
        bit do_push, do_pop;
        @(negedge clk);
        if (model_known) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("validd", 32'(validd), 32'(sb.size() != 0));
            chk("readyf", 32'(readyf), 32'(sb.size() != DEPTH));
            chk("instrd", instrd, (sb.size() != 0) ? sb[0].instr : 32'h0);
            chk("pcplus4d", pcplus4d, (sb.size() != 0) ? sb[0].pc : 32'h0);
        end
        reset = rst; validf = v; instrf = ins; pcplus4f = pc; stalld = stall; flushd = flush;
        if (rst || flush) begin
            sb.delete();
            if (rst) model_known = 1;
        end else begin
            do_push = v && (sb.size() < DEPTH);
            do_pop  = (sb.size() != 0) && !stall;
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back('{ins, pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string name, input int exp_count,
                        input logic exp_validd, input logic exp_readyf);
        chk({name, ".count"}, 32'(count), 32'(exp_count));
        chk({name, ".validd"}, 32'(validd), 32'(exp_validd));
        chk({name, ".readyf"}, 32'(readyf), 32'(exp_readyf));
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        // reset, idle, single pass, fill under stall (A4 refused), drain in order
        vecs[0]  = '{1, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, 32'h20080005, 32'h4,   0, 0, 1, 1, 1};
        vecs[3]  = '{0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1};
        vecs[4]  = '{0, 1, 32'hA0000000, 32'h100, 1, 0, 1, 1, 1};
        vecs[5]  = '{0, 1, 32'hA0000001, 32'h104, 1, 0, 2, 1, 1};
        vecs[6]  = '{0, 1, 32'hA0000002, 32'h108, 1, 0, 3, 1, 1};
        vecs[7]  = '{0, 1, 32'hA0000003, 32'h10C, 1, 0, 4, 1, 0};
        vecs[8]  = '{0, 1, 32'hA0000004, 32'h110, 1, 0, 4, 1, 0};
        vecs[9]  = '{0, 0, 32'h0,        32'h0,   0, 0, 3, 1, 1};
        vecs[10] = '{0, 0, 32'h0,        32'h0,   0, 0, 2, 1, 1};
        vecs[11] = '{0, 0, 32'h0,        32'h0,   0, 0, 1, 1, 1};
        vecs[12] = '{0, 0, 32'h0,        32'h0,   0, 0, 0, 0, 1};
        vecs[13] = '{0, 0, 32'h0,        32'h0,   1, 0, 0, 0, 1};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].stall, vecs[i].flush);
            post($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_validd, vecs[i].exp_readyf);
        end
        chk("post_reset.instrd", instrd, 32'h0);

        // steady stream, one in one out, pointers wrap several times
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 32'hC0000000 + 32'(k), 32'h200 + 32'(4 * k), 0, 0);
            post($sformatf("wrap%0d", k), 1, 1, 1);
        end
        idle();
        post("wrap_end", 0, 0, 1);

        // full with pop requested and fetch still valid: only the pop happens
        for (int k = 0; k < 4; k++) step(0, 1, 32'hE0000000 + 32'(k), 32'h300 + 32'(4 * k), 1, 0);
        step(0, 1, 32'hEEEEEEEE, 32'h3F0, 0, 0);
        post("full_pop", 3, 1, 1);
        for (int k = 0; k < 3; k++) idle();
        post("full_drain", 0, 0, 1);

        // flush while pushing B: B dropped, later push flows normally
        for (int k = 0; k < 3; k++) step(0, 1, 32'h10000000 + 32'(k), 32'h400 + 32'(4 * k), 1, 0);
        step(0, 1, 32'hBBBBBBBB, 32'h4B0, 0, 1);
        post("flush", 0, 0, 1);
        chk("flush.instrd", instrd, 32'h0);
        chk("flush.pcplus4d", pcplus4d, 32'h0);
        step(0, 1, 32'hD0000001, 32'h500, 1, 0);
        post("after_flush", 1, 1, 1);
        chk("after_flush.instrd", instrd, 32'hD0000001);
        idle();
        post("after_flush_pop", 0, 0, 1);

        // reset mid-operation with push and pop both requested
        for (int k = 0; k < 2; k++) step(0, 1, 32'hF0000000 + 32'(k), 32'h600 + 32'(4 * k), 1, 0);
        post("pre_reset", 2, 1, 1);
        step(1, 1, 32'hF00000FF, 32'h6F0, 0, 0);
        post("mid_reset", 0, 0, 1);
        chk("mid_reset.instrd", instrd, 32'h0);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
